// File: rtl/switch_allocator.sv
// Switch allocator: one round-robin winner per output port, with a boost for starved inputs.
// Latency: grants, crossbar selects, output enables and credits are combinational (0 cycles).
// Backpressure: a full output takes no candidates that cycle; its requesters' starve counters hold.
module switch_allocator #(
    parameter int NPORTS   = 5,
    parameter int PSEL_W   = 3,
    parameter int STARVE_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NPORTS-1:0]        req_valid_i,
    input  logic [NPORTS*PSEL_W-1:0] req_port_i,
    input  logic [NPORTS-1:0]        out_full_i,
    output logic [NPORTS-1:0]        grant_o,
    output logic [NPORTS-1:0]        credit_o,
    output logic [NPORTS-1:0]        out_enable_o,
    output logic [NPORTS*PSEL_W-1:0] out_select_o,
    output logic                     err_o
);

    // One extra bit so that ptr + offset cannot overflow before the wrap.
    localparam int IW = PSEL_W + 1;
    localparam logic [STARVE_W-1:0] STARVE_MAX = '1;

    logic [PSEL_W-1:0]        ptr_q    [NPORTS];
    logic [PSEL_W-1:0]        ptr_d    [NPORTS];
    logic [STARVE_W-1:0]      starve_q [NPORTS];
    logic [STARVE_W-1:0]      starve_d [NPORTS];
    logic                     err_q;
    logic                     err_d;

    logic [NPORTS-1:0]        legal;
    logic [NPORTS-1:0]        sat;
    logic [NPORTS-1:0]        grant_c;
    logic [NPORTS-1:0]        enable_c;
    logic [NPORTS*PSEL_W-1:0] select_c;

    logic [NPORTS-1:0]        cand;
    logic                     any_sat;
    logic                     found;
    logic [IW-1:0]            idx;
    logic [PSEL_W-1:0]        win;
    logic [PSEL_W-1:0]        port_c;
    logic                     blocked;

    // Per-input decode: is the requested port code in range, and is the input saturated.
    always_comb begin
        legal = '0;
        sat   = '0;
        for (int i = 0; i < NPORTS; i++) begin
            legal[i] = (req_port_i[i*PSEL_W +: PSEL_W] < PSEL_W'(NPORTS));
            sat[i]   = (starve_q[i] == STARVE_MAX);
        end
    end

    // Independent arbitration per output: saturated candidates first, then round robin from ptr.
    always_comb begin
        grant_c  = '0;
        enable_c = '0;
        select_c = '0;
        cand     = '0;
        any_sat  = 1'b0;
        found    = 1'b0;
        idx      = '0;
        win      = '0;
        for (int o = 0; o < NPORTS; o++) begin
            ptr_d[o] = ptr_q[o];
            // An out-of-range code never equals a real output, so illegal requests drop out here.
            for (int i = 0; i < NPORTS; i++) begin
                cand[i] = req_valid_i[i] && (req_port_i[i*PSEL_W +: PSEL_W] == PSEL_W'(o))
                          && !out_full_i[o];
            end
            any_sat = |(cand & sat);
            found   = 1'b0;
            win     = '0;
            for (int k = 0; k < NPORTS; k++) begin
                idx = {1'b0, ptr_q[o]} + IW'(k);
                if (idx >= IW'(NPORTS)) begin
                    idx = idx - IW'(NPORTS);
                end
                if (!found && cand[idx[PSEL_W-1:0]] && (!any_sat || sat[idx[PSEL_W-1:0]])) begin
                    found = 1'b1;
                    win   = idx[PSEL_W-1:0];
                end
            end
            // Reset suppresses every strobe; the pointer update is irrelevant then.
            if (found && !rst) begin
                grant_c[win]                    = 1'b1;
                enable_c[o]                     = 1'b1;
                select_c[o*PSEL_W +: PSEL_W]    = win;
                ptr_d[o] = (win == PSEL_W'(NPORTS-1)) ? '0 : win + 1'b1;
            end
        end
    end

    // Starvation counters: clear on grant or idle, hold under backpressure or illegal code, else count.
    always_comb begin
        port_c  = '0;
        blocked = 1'b0;
        for (int i = 0; i < NPORTS; i++) begin
            port_c      = req_port_i[i*PSEL_W +: PSEL_W];
            blocked     = legal[i] ? out_full_i[port_c] : 1'b1;
            starve_d[i] = starve_q[i];
            if (!req_valid_i[i] || grant_c[i]) begin
                starve_d[i] = '0;
            end else if (!blocked && !sat[i]) begin
                starve_d[i] = starve_q[i] + 1'b1;
            end
        end
        err_d = err_q | (|(req_valid_i & ~legal));
    end

    // Registered arbitration state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int o = 0; o < NPORTS; o++) begin
                ptr_q[o]    <= '0;
                starve_q[o] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            for (int o = 0; o < NPORTS; o++) begin
                ptr_q[o]    <= ptr_d[o];
                starve_q[o] <= starve_d[o];
            end
            err_q <= err_d;
        end
    end

    assign grant_o      = grant_c;
    assign credit_o     = grant_c;
    assign out_enable_o = enable_c;
    assign out_select_o = select_c;
    assign err_o        = err_q;

endmodule

// File: tb/tb_switch_allocator.sv
// Bench for switch_allocator: directed scenarios plus random traffic against a reference model.
// Inputs change on the falling edge; outputs are sampled 1 time unit later, state advances on the rising edge.
// The model holds per-output pointers, per-input starve counts and the sticky error as plain integers.
module tb_switch_allocator;

    localparam int N    = 5;
    localparam int PW   = 3;
    localparam int SW   = 2;
    localparam int SMAX = (1 << SW) - 1;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N*PW-1:0] req_port;
    logic [N-1:0]    out_full;
    logic [N-1:0]    grant;
    logic [N-1:0]    credit;
    logic [N-1:0]    out_enable;
    logic [N*PW-1:0] out_select;
    logic            err;

    switch_allocator #(.NPORTS(N), .PSEL_W(PW), .STARVE_W(SW)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid_i  (req_valid),
        .req_port_i   (req_port),
        .out_full_i   (out_full),
        .grant_o      (grant),
        .credit_o     (credit),
        .out_enable_o (out_enable),
        .out_select_o (out_select),
        .err_o        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Stimulus for the next cycle.
    logic         s_rst;
    logic [N-1:0] s_valid;
    logic [N-1:0] s_full;
    int           s_port [N];

    // Reference model state.
    int m_ptr    [N];
    int m_starve [N];
    int m_err;

    // Outputs captured in the most recent cycle.
    logic [N-1:0]    obs_grant;
    logic [N-1:0]    obs_en;
    logic [N*PW-1:0] obs_sel;
    logic            obs_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic clear_stim();
        s_rst   = 1'b0;
        s_valid = '0;
        s_full  = '0;
        for (int i = 0; i < N; i++) s_port[i] = 0;
    endtask

    task automatic set_req(input int i, input int p);
        s_valid[i] = 1'b1;
        s_port[i]  = p;
    endtask

    // One clock cycle: drive, predict, compare, then advance the model on the rising edge.
    task automatic run_cycle();
        logic [N-1:0]    e_grant;
        logic [N-1:0]    e_en;
        logic [N*PW-1:0] e_sel;
        int              win [N];
        int              i;
        @(negedge clk);
        rst       = s_rst;
        req_valid = s_valid;
        out_full  = s_full;
        for (int k = 0; k < N; k++) req_port[k*PW +: PW] = 3'(s_port[k]);
        #1;
        e_grant = '0;
        e_en    = '0;
        e_sel   = '0;
        for (int o = 0; o < N; o++) begin
            win[o] = -1;
            if (!s_rst && !s_full[o]) begin
                // Walk from the pointer; a saturated requester replaces any unsaturated pick so far.
                for (int k = 0; k < N; k++) begin
                    i = (m_ptr[o] + k) % N;
                    if (s_valid[i] && s_port[i] == o) begin
                        if (win[o] < 0) win[o] = i;
                        else if (m_starve[i] == SMAX && m_starve[win[o]] != SMAX) win[o] = i;
                    end
                end
            end
            if (win[o] >= 0) begin
                e_grant[win[o]]    = 1'b1;
                e_en[o]            = 1'b1;
                e_sel[o*PW +: PW]  = 3'(win[o]);
            end
        end
        obs_grant = grant;
        obs_en    = out_enable;
        obs_sel   = out_select;
        obs_err   = err;
        chk("grant",      32'(grant),      32'(e_grant));
        chk("credit",     32'(credit),     32'(e_grant));
        chk("out_enable", 32'(out_enable), 32'(e_en));
        chk("out_select", 32'(out_select), 32'(e_sel));
        chk("err",        32'(err),        32'(m_err));
        @(posedge clk);
        if (s_rst) begin
            for (int k = 0; k < N; k++) begin
                m_ptr[k]    = 0;
                m_starve[k] = 0;
            end
            m_err = 0;
        end else begin
            for (int o = 0; o < N; o++) if (win[o] >= 0) m_ptr[o] = (win[o] + 1) % N;
            for (int k = 0; k < N; k++) begin
                if (!s_valid[k] || e_grant[k]) m_starve[k] = 0;
                else if (s_port[k] >= N) m_err = 1;
                else if (!s_full[s_port[k]] && m_starve[k] < SMAX) m_starve[k]++;
            end
        end
    endtask

    task automatic do_reset(input int cycles);
        clear_stim();
        s_rst   = 1'b1;
        s_valid = '1;
        for (int k = 0; k < cycles; k++) begin
            run_cycle();
            chk("rst_grant", 32'(obs_grant), 32'd0);
            chk("rst_en",    32'(obs_en),    32'd0);
        end
        s_rst = 1'b0;
    endtask

    int rr_exp [6] = '{1, 3, 4, 1, 3, 4};

    initial begin
        for (int k = 0; k < N; k++) begin
            m_ptr[k]    = 0;
            m_starve[k] = 0;
        end
        m_err = 0;
        clear_stim();
        rst       = 1'b1;
        req_valid = '0;
        req_port  = '0;
        out_full  = '0;

        // Reset with every input requesting, then contention on E goes to input 0.
        do_reset(3);
        clear_stim();
        for (int k = 0; k < N; k++) set_req(k, 2);
        run_cycle();
        chk("first_grant", 32'(obs_grant), 32'b00001);
        chk("first_sel_E", 32'(obs_sel[2*PW +: PW]), 32'd0);

        // Round robin on E among S, W, L.
        do_reset(1);
        clear_stim();
        set_req(1, 2); set_req(3, 2); set_req(4, 2);
        for (int c = 0; c < 6; c++) begin
            run_cycle();
            chk("rr_sel_E", 32'(obs_sel[2*PW +: PW]), 32'(rr_exp[c]));
            chk("rr_en_E",  32'(obs_en[2]), 32'd1);
        end

        // Four independent transfers in one cycle.
        do_reset(1);
        clear_stim();
        set_req(0, 1); set_req(1, 4); set_req(3, 0); set_req(4, 3);
        run_cycle();
        chk("par_grant", 32'(obs_grant), 32'b11011);
        chk("par_sel_S", 32'(obs_sel[1*PW +: PW]), 32'd0);
        chk("par_sel_L", 32'(obs_sel[4*PW +: PW]), 32'd1);
        chk("par_sel_N", 32'(obs_sel[0*PW +: PW]), 32'd3);
        chk("par_sel_W", 32'(obs_sel[3*PW +: PW]), 32'd4);

        // Backpressure on E for 20 cycles, then release.
        do_reset(1);
        clear_stim();
        set_req(1, 2); set_req(3, 2);
        s_full[2] = 1'b1;
        for (int c = 0; c < 20; c++) run_cycle();
        s_full[2] = 1'b0;
        run_cycle();
        chk("bp_release", 32'(obs_grant), 32'b00010);

        // Starvation boost on L: input 0 loses three times, then beats input 4 despite ptr=4.
        do_reset(1);
        clear_stim();
        set_req(0, 4);
        run_cycle();
        for (int c = 1; c <= 4; c++) begin
            clear_stim();
            set_req(0, 4);
            set_req(c, 4);
            run_cycle();
        end
        chk("starve_win", 32'(obs_grant), 32'b00001);
        chk("starve_sel", 32'(obs_sel[4*PW +: PW]), 32'd0);
        run_cycle();
        chk("starve_clr", 32'(obs_sel[4*PW +: PW]), 32'd4);

        // Illegal port code on input 2; input 0 keeps using S.
        do_reset(1);
        clear_stim();
        set_req(2, 6); set_req(0, 1);
        run_cycle();
        chk("ill_err0",  32'(obs_err), 32'd0);
        chk("ill_other", 32'(obs_grant), 32'b00001);
        for (int c = 0; c < 4; c++) begin
            run_cycle();
            chk("ill_err1",  32'(obs_err), 32'd1);
            chk("ill_grant", 32'(obs_grant[2]), 32'd0);
        end
        clear_stim();
        run_cycle();
        chk("ill_sticky", 32'(obs_err), 32'd1);
        do_reset(1);
        run_cycle();
        chk("ill_cleared", 32'(obs_err), 32'd0);

        // Random traffic, occasional resets and illegal codes.
        for (int c = 0; c < 2000; c++) begin
            clear_stim();
            s_rst = ($urandom_range(0, 49) == 0);
            for (int k = 0; k < N; k++) begin
                s_valid[k] = ($urandom_range(0, 3) != 0);
                s_port[k]  = ($urandom_range(0, 63) == 0) ? int'($urandom_range(5, 7))
                                                          : int'($urandom_range(0, 4));
                s_full[k]  = ($urandom_range(0, 3) == 0);
            end
            run_cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
